// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches from instruction memory over req/ack and
// presents each word to decode over valid/ready. Branch redirect when
// branch & ALU_zero in HOLD; traps to a sticky ERROR state on memory timeout.
// Optional: FETCH_ALIGN_CHECK_EN traps a misaligned computed fetch address.
module fetch_sequencer #(
    parameter int unsigned         PC_WIDTH       = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC       = '0,
    parameter int unsigned         TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                branch,
    input  logic                ALU_zero,
    input  logic [63:0]         branch_offset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [PC_WIDTH-1:0] pc,
    output logic [31:0]         instruction,
    output logic                fetch_err
);

    localparam int unsigned   CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        ERROR
    } state_t;

    state_t              state, state_next;
    logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_next;
    logic [PC_WIDTH-1:0] addr_next, pc_next, target;
    logic                req_next, valid_next, err_next;
    logic [31:0]         instr_next;
    logic [CW-1:0]       count, count_next;

    // Only the low PC_WIDTH bits of the offset take part in the sum.
    generate
        if (PC_WIDTH < 64) begin : g_unused
            logic unused_offset_bits;
            assign unused_offset_bits = ^branch_offset[63:PC_WIDTH];
        end
    endgenerate

    // State and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            imem_addr   <= RESET_PC;
            imem_req    <= 1'b0;
            if_valid    <= 1'b0;
            pc          <= RESET_PC;
            instruction <= '0;
            fetch_err   <= 1'b0;
            count       <= '0;
        end else begin
            state       <= state_next;
            fetch_pc    <= fetch_pc_next;
            imem_addr   <= addr_next;
            imem_req    <= req_next;
            if_valid    <= valid_next;
            pc          <= pc_next;
            instruction <= instr_next;
            fetch_err   <= err_next;
            count       <= count_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        addr_next     = imem_addr;
        req_next      = imem_req;
        valid_next    = if_valid;
        pc_next       = pc;
        instr_next    = instruction;
        err_next      = fetch_err;
        count_next    = count;
        target        = (branch & ALU_zero) ? pc + branch_offset[PC_WIDTH-1:0]
                                            : pc + PC_WIDTH'(4);
        case (state)
            IDLE: begin
                state_next = FETCH;
                req_next   = 1'b1;
                addr_next  = fetch_pc;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    pc_next    = fetch_pc;
                    valid_next = 1'b1;
                    req_next   = 1'b0;
                    count_next = '0;
                    state_next = HOLD;
                end else if (count == CNT_LAST) begin
                    req_next   = 1'b0;
                    err_next   = 1'b1;
                    state_next = ERROR;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            HOLD: begin
                if (if_ready) begin
                    valid_next    = 1'b0;
                    fetch_pc_next = target;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (target[1:0] != 2'b00) begin
                        err_next   = 1'b1;
                        state_next = ERROR;
                    end else begin
                        req_next   = 1'b1;
                        addr_next  = target;
                        state_next = FETCH;
                    end
`else
                    req_next   = 1'b1;
                    addr_next  = target;
                    state_next = FETCH;
`endif
                end
            end
            ERROR: begin
                req_next   = 1'b0;
                valid_next = 1'b0;
                err_next   = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: table of fetch transactions plus hand-written
// timeout, reset-mid-fetch and alignment sequences. Inputs driven and outputs
// sampled on the falling clock edge.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch, ALU_zero, imem_ack, if_ready;
    logic [63:0] branch_offset;
    logic [31:0] imem_rdata;
    logic        imem_req, if_valid, fetch_err;
    logic [31:0] imem_addr, pc, instruction;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] addr;
        int          ack_delay;
        int          ready_delay;
        logic        br;
        logic        zero;
        logic [63:0] off;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs[8];

    fetch_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .branch(branch), .ALU_zero(ALU_zero),
        .branch_offset(branch_offset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_ready(if_ready), .pc(pc), .instruction(instruction), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete fetch/decode transaction driven from a vector.
    task automatic do_fetch(input vec_t v);
        exp_t e;
        int   n;
        n = 0;
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", imem_req, 1'b1);
        check("req_addr", imem_addr, v.addr);
        sb.push_back('{pc: v.addr, instr: v.rdata});
        if_ready = 1'b1;               // ignored outside HOLD
        repeat (v.ack_delay) begin
            @(negedge clk);
            check("req_held", imem_req, 1'b1);
            check("addr_stable", imem_addr, v.addr);
        end
        if_ready   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = v.rdata;
        @(negedge clk);
        check("valid_set", if_valid, 1'b1);
        check("req_dropped", imem_req, 1'b0);
        if (sb.size() == 0) begin
            check("sb_nonempty", 1'b0, 1'b1);
        end else begin
            e = sb.pop_front();
            check("hold_pc", pc, e.pc);
            check("hold_instr", instruction, e.instr);
        end
        // Ignored while HOLD without ready: stray ack and branch inputs.
        imem_rdata    = ~v.rdata;
        branch        = 1'b1;
        ALU_zero      = 1'b1;
        branch_offset = 64'h3;
        repeat (v.ready_delay) begin
            @(negedge clk);
            check("stall_valid", if_valid, 1'b1);
            check("stall_pc", pc, v.addr);
            check("stall_instr", instruction, v.rdata);
            check("stall_req", imem_req, 1'b0);
        end
        imem_ack      = 1'b0;
        if_ready      = 1'b1;
        branch        = v.br;
        ALU_zero      = v.zero;
        branch_offset = v.off;
        @(negedge clk);
        if_ready      = 1'b0;
        branch        = 1'b0;
        ALU_zero      = 1'b0;
        branch_offset = 64'h0;
        check("valid_clear", if_valid, 1'b0);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{32'h0000_0000, 0, 0, 1'b0, 1'b0, 64'h0, 32'h1111_0001};
        vecs[1] = '{32'h0000_0004, 2, 5, 1'b1, 1'b1, 64'hFC, 32'h2222_0002};
        vecs[2] = '{32'h0000_0100, 0, 0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 32'h3333_0003};
        vecs[3] = '{32'h0000_00F0, 1, 1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 32'h4444_0004};
        vecs[4] = '{32'h0000_00F4, 0, 2, 1'b0, 1'b1, 64'h40, 32'h5555_0005};
        vecs[5] = '{32'h0000_00F8, 3, 0, 1'b1, 1'b1, 64'h1234_5678_FFFF_FF04, 32'h6666_0006};
        vecs[6] = '{32'hFFFF_FFFC, 0, 0, 1'b0, 1'b0, 64'h10, 32'h7777_0007};
        vecs[7] = '{32'h0000_0000, 15, 0, 1'b1, 1'b1, 64'h8, 32'h8888_0008};

        rst = 1'b1; branch = 1'b0; ALU_zero = 1'b0; branch_offset = '0;
        imem_ack = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", if_valid, 1'b0);
        check("rst_pc", pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check("rst_err", fetch_err, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) do_fetch(vecs[i]);

        // Timeout: fetch at 0x8 never acknowledged.
        check("to_req", imem_req, 1'b1);
        check("to_addr", imem_addr, 32'h8);
        repeat (15) @(negedge clk);
        check("to_last_req", imem_req, 1'b1);
        check("to_last_err", fetch_err, 1'b0);
        @(negedge clk);
        check("to_err", fetch_err, 1'b1);
        check("to_req_low", imem_req, 1'b0);
        imem_ack = 1'b1; if_ready = 1'b1;
        repeat (4) @(negedge clk);
        imem_ack = 1'b0; if_ready = 1'b0;
        check("err_sticky", fetch_err, 1'b1);
        check("err_req", imem_req, 1'b0);
        check("err_valid", if_valid, 1'b0);

        // Reset mid-FETCH with a late ack during the IDLE cycle.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mf_req", imem_req, 1'b1);
        rst = 1'b1;
        #1;
        check("mf_req_async", imem_req, 1'b0);
        check("mf_err_async", fetch_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        check("late_ack_valid", if_valid, 1'b0);
        check("late_ack_req", imem_req, 1'b1);
        check("late_ack_addr", imem_addr, 32'h0);
        @(negedge clk);
        check("late_ack_still", if_valid, 1'b0);

        // Taken branch with offset +2 gives a misaligned target.
        v = '{32'h0000_0000, 0, 0, 1'b1, 1'b1, 64'h2, 32'h9999_0009};
        do_fetch(v);
`ifdef FETCH_ALIGN_CHECK_EN
        check("align_err", fetch_err, 1'b1);
        check("align_req", imem_req, 1'b0);
`else
        check("misalign_req", imem_req, 1'b1);
        check("misalign_addr", imem_addr, 32'h2);
        check("misalign_err", fetch_err, 1'b0);
`endif
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
